// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 lane demultiplexer / collector.
// Also used by the multiplexer side for lane indexing.
//   LANES, SEL_W : lane count and select width
//   state_e      : collector states (FILL, HOLD)
//   onehot()     : 2-bit lane select -> 4-bit one-hot lane mask
package demux_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    function automatic logic [LANES-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [LANES-1:0] mask;
        mask = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/demux_1to4.sv
// Combinational lane write-enable decoder.
// Ports:
//   sel : destination lane select
//   en  : write strobe; no lane is enabled while low
//   we  : one-hot per-lane write enables
module demux_1to4
    import demux_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [LANES-1:0] we
);

    assign we = en ? onehot(sel) : '0;

endmodule

// File: rtl/demux_1to4_collector.sv
// Registered 1-to-4 demultiplexer that collects one element per lane and
// presents the assembled word once all four lanes have been written.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_data/in_sel      : element and destination lane
//   in_valid/in_ready   : input handshake (in_ready depends on state only)
//   flush               : discard partial or held word
//   out_word            : assembled word, lane k at [k*DATA_W +: DATA_W]
//   out_valid/out_ready : output handshake
//   fill                : per-lane written flags
//   dup_err             : one-cycle pulse after a write to an already-filled lane
module demux_1to4_collector
    import demux_pkg::*;
#(
    parameter int DATA_W = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    output logic [LANES*DATA_W-1:0] out_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      fill,
    output logic                  dup_err
);

    state_e             state_reg;
    logic [LANES-1:0]   fill_reg;
    logic               dup_err_reg;
    logic [DATA_W-1:0]  lane_reg [LANES];

    logic               accept;
    logic               wr_en;
    logic [LANES-1:0]   lane_we;
    logic [LANES-1:0]   fill_next;

    assign accept    = in_valid && (state_reg == FILL);
    // A flush in the same cycle drops the element entirely.
    assign wr_en     = accept && !flush;
    assign fill_next = fill_reg | lane_we;

    demux_1to4 u_dec (
        .sel (in_sel),
        .en  (wr_en),
        .we  (lane_we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FILL;
            fill_reg    <= '0;
            dup_err_reg <= 1'b0;
        end else begin
            dup_err_reg <= 1'b0;
            if (flush) begin
                state_reg <= FILL;
                fill_reg  <= '0;
            end else begin
                case (state_reg)
                    FILL: begin
                        if (wr_en) begin
                            fill_reg    <= fill_next;
                            dup_err_reg <= |(fill_reg & lane_we);
                            if (&fill_next) begin
                                state_reg <= HOLD;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state_reg <= FILL;
                            fill_reg  <= '0;
                        end
                    end
                    default: begin
                        state_reg <= FILL;
                        fill_reg  <= '0;
                    end
                endcase
            end
        end
    end

    // Lane storage; lane data is left stale when a word completes or is flushed.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg[gi] <= '0;
                end else if (lane_we[gi]) begin
                    lane_reg[gi] <= in_data;
                end
            end
            assign out_word[gi*DATA_W +: DATA_W] = lane_reg[gi];
        end
    endgenerate

    assign in_ready  = (state_reg == FILL);
    assign out_valid = (state_reg == HOLD);
    assign fill      = fill_reg;
    assign dup_err   = dup_err_reg;

endmodule

// File: tb/tb_demux_1to4_collector.sv
module tb_demux_1to4_collector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT a: DATA_W = 1
    logic        rst_a, in_valid_a, flush_a, out_ready_a;
    logic [0:0]  in_data_a;
    logic [1:0]  in_sel_a;
    logic        in_ready_a, out_valid_a, dup_err_a;
    logic [3:0]  out_word_a, fill_a;

    // DUT b: DATA_W = 4
    logic        rst_b, in_valid_b, flush_b, out_ready_b;
    logic [3:0]  in_data_b;
    logic [1:0]  in_sel_b;
    logic        in_ready_b, out_valid_b, dup_err_b;
    logic [15:0] out_word_b;
    logic [3:0]  fill_b;

    demux_1to4_collector #(.DATA_W(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_data(in_data_a), .in_sel(in_sel_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .flush(flush_a),
        .out_word(out_word_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .fill(fill_a), .dup_err(dup_err_a)
    );

    demux_1to4_collector #(.DATA_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .in_data(in_data_b), .in_sel(in_sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
        .out_word(out_word_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .fill(fill_b), .dup_err(dup_err_b)
    );

    typedef struct {
        logic [1:0] sel;
        logic [3:0] data;
        logic [3:0] exp_fill;
        logic       exp_dup;
        logic       exp_valid;
    } rec_t;

    int total = 0;
    int bad = 0;
    logic [15:0] sb_q[$];
    logic [3:0]  model_a [4];
    logic [3:0]  model_b [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write on DUT a, checked against the table record after the edge.
    task automatic write_a(input rec_t r, input string tag);
        in_valid_a = 1'b1;
        in_sel_a   = r.sel;
        in_data_a  = r.data[0];
        step();
        model_a[r.sel] = r.data;
        in_valid_a = 1'b0;
        check({tag, ".fill"},  {12'd0, fill_a},     {12'd0, r.exp_fill});
        check({tag, ".dup"},   {15'd0, dup_err_a},  {15'd0, r.exp_dup});
        check({tag, ".valid"}, {15'd0, out_valid_a}, {15'd0, r.exp_valid});
        if (r.exp_valid)
            sb_q.push_back({12'd0, model_a[3][0], model_a[2][0], model_a[1][0], model_a[0][0]});
    endtask

    // Consume the held word on DUT a via the out_ready handshake.
    task automatic consume_a(input string tag);
        logic [15:0] exp;
        out_ready_a = 1'b1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s.sb: got empty queue expected an entry", tag);
        end else begin
            exp = sb_q.pop_front();
            check({tag, ".word"}, {12'd0, out_word_a}, exp);
        end
        step();
        out_ready_a = 1'b0;
        check({tag, ".post_valid"}, {15'd0, out_valid_a}, 16'd0);
        check({tag, ".post_fill"},  {12'd0, fill_a},      16'd0);
        check({tag, ".post_ready"}, {15'd0, in_ready_a},  16'd1);
    endtask

    rec_t seq1 [4];
    rec_t seq3 [5];
    rec_t seq4 [4];
    rec_t seq5 [4];
    rec_t seqb [4];

    initial begin
        seq1 = '{'{2'd0, 4'h0, 4'b0001, 1'b0, 1'b0},
                 '{2'd1, 4'h1, 4'b0011, 1'b0, 1'b0},
                 '{2'd2, 4'h0, 4'b0111, 1'b0, 1'b0},
                 '{2'd3, 4'h1, 4'b1111, 1'b0, 1'b1}};
        seq3 = '{'{2'd2, 4'h1, 4'b0100, 1'b0, 1'b0},
                 '{2'd0, 4'h0, 4'b0101, 1'b0, 1'b0},
                 '{2'd2, 4'h0, 4'b0101, 1'b1, 1'b0},
                 '{2'd1, 4'h1, 4'b0111, 1'b0, 1'b0},
                 '{2'd3, 4'h1, 4'b1111, 1'b0, 1'b1}};
        seq4 = '{'{2'd0, 4'h1, 4'b0001, 1'b0, 1'b0},
                 '{2'd1, 4'h1, 4'b0011, 1'b0, 1'b0},
                 '{2'd2, 4'h1, 4'b0111, 1'b0, 1'b0},
                 '{2'd3, 4'h1, 4'b1111, 1'b0, 1'b1}};
        seq5 = '{'{2'd0, 4'h0, 4'b0001, 1'b0, 1'b0},
                 '{2'd1, 4'h1, 4'b0011, 1'b0, 1'b0},
                 '{2'd2, 4'h1, 4'b0111, 1'b0, 1'b0},
                 '{2'd3, 4'h0, 4'b1111, 1'b0, 1'b1}};
        seqb = '{'{2'd3, 4'hA, 4'b1000, 1'b0, 1'b0},
                 '{2'd2, 4'hB, 4'b1100, 1'b0, 1'b0},
                 '{2'd1, 4'hC, 4'b1110, 1'b0, 1'b0},
                 '{2'd0, 4'hD, 4'b1111, 1'b0, 1'b1}};

        rst_a = 1'b1; in_valid_a = 1'b0; flush_a = 1'b0; out_ready_a = 1'b0;
        in_data_a = '0; in_sel_a = '0;
        rst_b = 1'b1; in_valid_b = 1'b0; flush_b = 1'b0; out_ready_b = 1'b0;
        in_data_b = '0; in_sel_b = '0;
        for (int i = 0; i < 4; i++) begin model_a[i] = '0; model_b[i] = '0; end
        step(); step();
        rst_a = 1'b0; rst_b = 1'b0;
        step();

        // Reset state
        check("rst.fill",  {12'd0, fill_a},      16'd0);
        check("rst.valid", {15'd0, out_valid_a}, 16'd0);
        check("rst.ready", {15'd0, in_ready_a},  16'd1);
        check("rst.dup",   {15'd0, dup_err_a},   16'd0);
        check("rst.word",  {12'd0, out_word_a},  16'd0);

        // In-order fill, then hold 5 cycles with stable word
        for (int i = 0; i < 4; i++) write_a(seq1[i], $sformatf("w1[%0d]", i));
        check("w1.word", {12'd0, out_word_a}, 16'h000A);
        check("w1.ready", {15'd0, in_ready_a}, 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hold[%0d].word", i), {12'd0, out_word_a}, 16'h000A);
            check($sformatf("hold[%0d].valid", i), {15'd0, out_valid_a}, 16'd1);
        end
        consume_a("c1");

        // Duplicate write: last write wins, one dup_err pulse
        for (int i = 0; i < 5; i++) write_a(seq3[i], $sformatf("w3[%0d]", i));
        consume_a("c3");

        // Flush with a simultaneous write on lane 2
        write_a(seq4[0], "w4a[0]");
        write_a(seq4[1], "w4a[1]");
        flush_a = 1'b1; in_valid_a = 1'b1; in_sel_a = 2'd2; in_data_a = 1'b1;
        step();
        flush_a = 1'b0; in_valid_a = 1'b0;
        check("flush.fill", {12'd0, fill_a},    16'd0);
        check("flush.dup",  {15'd0, dup_err_a}, 16'd0);
        for (int i = 0; i < 4; i++) write_a(seq4[i], $sformatf("w4b[%0d]", i));
        consume_a("c4");

        // Flush in HOLD wins over out_ready
        for (int i = 0; i < 4; i++) write_a(seq5[i], $sformatf("w5[%0d]", i));
        check("w5.word", {12'd0, out_word_a}, {12'd0, sb_q[0][3:0]});
        void'(sb_q.pop_front());
        flush_a = 1'b1; out_ready_a = 1'b1;
        step();
        flush_a = 1'b0; out_ready_a = 1'b0;
        check("hflush.valid", {15'd0, out_valid_a}, 16'd0);
        check("hflush.fill",  {12'd0, fill_a},      16'd0);
        check("hflush.ready", {15'd0, in_ready_a},  16'd1);

        // Reset mid-fill
        write_a(seq1[0], "w6[0]");
        write_a(seq1[1], "w6[1]");
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        check("mrst.fill",  {12'd0, fill_a},      16'd0);
        check("mrst.valid", {15'd0, out_valid_a}, 16'd0);
        check("mrst.ready", {15'd0, in_ready_a},  16'd1);
        check("mrst.word",  {12'd0, out_word_a},  16'd0);
        check("mrst.dup",   {15'd0, dup_err_a},   16'd0);

        // Wide lanes on DUT b
        for (int i = 0; i < 4; i++) begin
            in_valid_b = 1'b1; in_sel_b = seqb[i].sel; in_data_b = seqb[i].data;
            step();
            model_b[seqb[i].sel] = seqb[i].data;
            in_valid_b = 1'b0;
            check($sformatf("wb[%0d].fill", i), {12'd0, fill_b}, {12'd0, seqb[i].exp_fill});
            check($sformatf("wb[%0d].valid", i), {15'd0, out_valid_b}, {15'd0, seqb[i].exp_valid});
            if (seqb[i].exp_valid) sb_q.push_back({model_b[3], model_b[2], model_b[1], model_b[0]});
        end
        out_ready_b = 1'b1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL wb.sb: got empty queue expected an entry");
        end else begin
            check("wb.word", out_word_b, sb_q.pop_front());
        end
        check("wb.const", out_word_b, 16'hABCD);
        step();
        out_ready_b = 1'b0;
        check("wb.post_valid", {15'd0, out_valid_b}, 16'd0);
        check("wb.post_ready", {15'd0, in_ready_b},  16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_1to4_collector.md
# demux_1to4_collector

Registered 1-to-4 demultiplexer with handshakes: routes each input element to the lane chosen by a 2-bit select, holds it, and presents the assembled 4-lane word once every lane has been written. It is the write-side counterpart of the 4-to-1 multiplexer in the PC datapath. It lets PC/immediate fragments arriving over a narrow path be reassembled into a full word for downstream consumption.

## Interface
- DATA_W, default 1: width of one lane element; out_word is 4*DATA_W.
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  element to store.
- in_sel  input  2  destination lane; lane k occupies out_word[k*DATA_W +: DATA_W].
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts an element this cycle.
- flush  input  1  discard the partial or held word.
- out_word  output  4*DATA_W  assembled word.
- out_valid  output  1  out_word complete and held.
- out_ready  input  1  consumer takes out_word.
- fill  output  4  per-lane written flags; bit k set once lane k is written.
- dup_err  output  1  one-cycle pulse: accepted write hit an already-filled lane.

## Operation
- Two states: FILL and HOLD.
- FILL:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready. On accept, lane[in_sel] <= in_data and fill[in_sel] <= 1.
  - Writing an already-filled lane overwrites its data (last write wins) and pulses dup_err next cycle.
  - When fill | onehot(in_sel) == 4'b1111 on an accept, go to HOLD.
- HOLD:
  - in_ready=0, out_valid=1. out_word, fill and lanes are stable.
  - When out_ready=1, go to FILL, clear fill to 0 and deassert out_valid. Lane data may keep stale values, but out_word is only meaningful while out_valid=1.
- flush=1 in either state:
  - Next state is FILL and fill clears to 0; a held word is discarded with no handshake.
  - flush has priority over a same-cycle accept (the element is dropped, dup_err not raised) and over out_ready.
  - in_ready stays as defined by the current state; elements offered during a flush cycle are lost by design.
- Reset values: state FILL, fill=0, lanes=0, out_word=0, out_valid=0, dup_err=0, in_ready=1 in the cycle after reset.
- rst has priority over flush and all handshakes. Reset mid-fill or mid-hold discards everything.
- No combinational path from out_ready or in_valid to in_ready. in_ready is a function of state only.

## Timing
- The 4th distinct-lane accept at edge N puts out_valid=1 and the complete out_word on output after edge N: 1-cycle latency.
- The HOLD→FILL handshake completes at the edge where out_valid & out_ready = 1. in_ready=1 from that edge on, so there is at least one bubble between the last write and the next accept. Minimum cycle per word: 4 accepts + 1 hold cycle.
- dup_err is high for exactly the cycle after the offending accept.
- fill updates at the same edge as the lane write.

## Structure
- Shared package `demux_pkg`:
  - LANES=4, SEL_W=2.
  - State enum {FILL, HOLD}.
  - Function onehot(sel) returning 4 bits.
- The package is reused by the existing multiplexer bench for lane indexing.
- Optional sub-module `demux_1to4`: a combinational sel→onehot write-enable decoder, instantiated once. All registers live in the top.

## Test plan
- After reset, write lanes 0..3 in order with DATA_W=1 and in_data = i[0] for i=0..3, out_ready=0 → out_valid=1 one cycle after the 4th write, out_word=4'b1010, in_ready=0, fill=4'b1111.
- Hold out_ready=0 for 5 cycles, then assert it for 1 cycle → out_word stable throughout. Next cycle: out_valid=0, fill=0, in_ready=1.
- Write lanes 2,0,2,1,3 with data 1,0,0,1,1 → dup_err pulses once (after the 3rd write), final out_word=4'b1010 (lane2 = 0), completing after the 5th write.
- Write lanes 0,1, then flush together with in_valid on lane 2 → fill=0, no dup_err. Then write lanes 0..3 with 1 → out_word=4'b1111.
- Assert flush in HOLD with out_ready=1 the same cycle → word discarded, state FILL, out_valid=0. Assert rst mid-fill (fill=4'b0011) → all outputs at reset values next cycle.
- DATA_W=4: write lanes 3,2,1,0 with 0xA,0xB,0xC,0xD → out_word=16'hABCD.
